sc_level_progress_counter: RTL and testbench

//  Producer side of the level handshake. Generates CurrentLevel and LvlProgressCount for
//  the level state machine, and consumes its LevelFinished, StartCount and FinishedGame flags.

---
 rtl/sc_level_progress_counter.sv | 113 +++++++++++
 tb/tb_sc_level_progress_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sc_level_progress_counter.sv
// sc_level_progress_counter: level and per-level progress producer for the level FSM handshake
// Ports:
//   SC_LEVEL_PROGRESS_CLOCK_50             clock, rising edge
//   SC_LEVEL_PROGRESS_RESET_InHigh         asynchronous active-high reset
//   SC_LEVEL_PROGRESS_Start_In             start button, rising edge starts the game
//   SC_LEVEL_PROGRESS_FrogAdvance_In       frog moved up a row, rising edge counts
//   SC_LEVEL_PROGRESS_FrogDeath_In         level-sensitive progress clear
//   SC_LEVEL_PROGRESS_LevelFinished_In     level complete flag from the level FSM
//   SC_LEVEL_PROGRESS_StartCount_In        1 = counting inhibited
//   SC_LEVEL_PROGRESS_FinishedGame_In      active-low game-over flag (informational only)
//   SC_LEVEL_PROGRESS_CurrentLevel_Out     current level, 0 = no game
//   SC_LEVEL_PROGRESS_LvlProgressCount_Out rows advanced in this level
//   SC_LEVEL_PROGRESS_LevelUp_Out          one-cycle pulse while the level increments
module sc_level_progress_counter #(
    parameter int LEVEL_DATAWIDTH    = 3,
    parameter int PROGRESS_DATAWIDTH = 5,
    parameter int PROGRESS_TARGET    = 20,
    parameter int MAX_LEVEL          = 3,
    parameter int STATE_DATAWIDTH    = 3
) (
    input  logic                          SC_LEVEL_PROGRESS_CLOCK_50,
    input  logic                          SC_LEVEL_PROGRESS_RESET_InHigh,
    input  logic                          SC_LEVEL_PROGRESS_Start_In,
    input  logic                          SC_LEVEL_PROGRESS_FrogAdvance_In,
    input  logic                          SC_LEVEL_PROGRESS_FrogDeath_In,
    input  logic                          SC_LEVEL_PROGRESS_LevelFinished_In,
    input  logic                          SC_LEVEL_PROGRESS_StartCount_In,
    input  logic                          SC_LEVEL_PROGRESS_FinishedGame_In,
    output logic [LEVEL_DATAWIDTH-1:0]    SC_LEVEL_PROGRESS_CurrentLevel_Out,
    output logic [PROGRESS_DATAWIDTH-1:0] SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    output logic                          SC_LEVEL_PROGRESS_LevelUp_Out
);
    localparam logic [STATE_DATAWIDTH-1:0] S_IDLE = STATE_DATAWIDTH'(0);
    localparam logic [STATE_DATAWIDTH-1:0] S_PLAY = STATE_DATAWIDTH'(1);
    localparam logic [STATE_DATAWIDTH-1:0] S_ADV  = STATE_DATAWIDTH'(2);
    localparam logic [STATE_DATAWIDTH-1:0] S_HOLD = STATE_DATAWIDTH'(3);
    localparam logic [STATE_DATAWIDTH-1:0] S_DONE = STATE_DATAWIDTH'(4);
    localparam logic [LEVEL_DATAWIDTH-1:0]    LVL_END = LEVEL_DATAWIDTH'(MAX_LEVEL + 1);
    localparam logic [PROGRESS_DATAWIDTH-1:0] TARGET  = PROGRESS_DATAWIDTH'(PROGRESS_TARGET);

    logic [STATE_DATAWIDTH-1:0]    state_q, state_d;
    logic [LEVEL_DATAWIDTH-1:0]    level_q, level_d, level_inc;
    logic [PROGRESS_DATAWIDTH-1:0] count_q, count_d;
    logic                          levelup_q, levelup_d;
    logic                          start_q, adv_q;
    logic                          start_edge, adv_edge, count_ok;
    logic                          unused_finished_game;

    // Game-over is already implied by the DONE state; the flag is accepted but not needed.
    assign unused_finished_game = SC_LEVEL_PROGRESS_FinishedGame_In;

    assign start_edge = SC_LEVEL_PROGRESS_Start_In & ~start_q;
    assign adv_edge   = SC_LEVEL_PROGRESS_FrogAdvance_In & ~adv_q;
    assign count_ok   = adv_edge & ~SC_LEVEL_PROGRESS_StartCount_In & (count_q < TARGET);
    assign level_inc  = (level_q < LVL_END) ? level_q + LEVEL_DATAWIDTH'(1) : level_q;

    always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50 or posedge SC_LEVEL_PROGRESS_RESET_InHigh) begin
        if (SC_LEVEL_PROGRESS_RESET_InHigh) begin
            state_q   <= S_IDLE;
            level_q   <= '0;
            count_q   <= '0;
            levelup_q <= 1'b0;
            start_q   <= 1'b0;
            adv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            count_q   <= count_d;
            levelup_q <= levelup_d;
            start_q   <= SC_LEVEL_PROGRESS_Start_In;
            adv_q     <= SC_LEVEL_PROGRESS_FrogAdvance_In;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = start_edge ? S_PLAY : S_IDLE;
            S_PLAY:  state_d = SC_LEVEL_PROGRESS_LevelFinished_In ? S_ADV : S_PLAY;
            S_ADV:   state_d = S_HOLD;
            S_HOLD:  state_d = (level_q == LVL_END) ? S_DONE :
                               SC_LEVEL_PROGRESS_LevelFinished_In ? S_HOLD : S_PLAY;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered; the ADVANCE values are loaded on the edge that enters
    // ADVANCE so LevelUp is high exactly while the state register holds ADVANCE.
    always_comb begin
        level_d   = '0;
        count_d   = '0;
        levelup_d = 1'b0;
        case (state_q)
            S_IDLE:  level_d = start_edge ? LEVEL_DATAWIDTH'(1) : '0;
            S_PLAY: begin
                level_d   = SC_LEVEL_PROGRESS_LevelFinished_In ? level_inc : level_q;
                levelup_d = SC_LEVEL_PROGRESS_LevelFinished_In;
                count_d   = SC_LEVEL_PROGRESS_LevelFinished_In ? '0 :
                            SC_LEVEL_PROGRESS_FrogDeath_In ? '0 :
                            count_ok ? count_q + PROGRESS_DATAWIDTH'(1) : count_q;
            end
            S_ADV:   level_d = level_q;
            S_HOLD:  level_d = level_q;
            S_DONE:  level_d = LVL_END;
            default: level_d = '0;
        endcase
    end

    assign SC_LEVEL_PROGRESS_CurrentLevel_Out     = level_q;
    assign SC_LEVEL_PROGRESS_LvlProgressCount_Out = count_q;
    assign SC_LEVEL_PROGRESS_LevelUp_Out          = levelup_q;
endmodule

// File: tb/tb_sc_level_progress_counter.sv
// tb_sc_level_progress_counter: directed plus randomized check against a behavioural model
module tb_sc_level_progress_counter;
    localparam int TGT = 20;
    localparam int LEND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, adv = 1'b0, death = 1'b0, lf = 1'b0, sc = 1'b0, fg = 1'b1;
    logic [2:0] level;
    logic [4:0] count;
    logic       lu;

    int vectors = 0;
    int errors = 0;

    sc_level_progress_counter dut (
        .SC_LEVEL_PROGRESS_CLOCK_50            (clk),
        .SC_LEVEL_PROGRESS_RESET_InHigh        (rst),
        .SC_LEVEL_PROGRESS_Start_In            (start),
        .SC_LEVEL_PROGRESS_FrogAdvance_In      (adv),
        .SC_LEVEL_PROGRESS_FrogDeath_In        (death),
        .SC_LEVEL_PROGRESS_LevelFinished_In    (lf),
        .SC_LEVEL_PROGRESS_StartCount_In       (sc),
        .SC_LEVEL_PROGRESS_FinishedGame_In     (fg),
        .SC_LEVEL_PROGRESS_CurrentLevel_Out    (level),
        .SC_LEVEL_PROGRESS_LvlProgressCount_Out(count),
        .SC_LEVEL_PROGRESS_LevelUp_Out         (lu)
    );

    always #5 clk = ~clk;

    // Behavioural model: game phase as flags, level/count as plain integers.
    bit started = 0, pulse = 0, waiting = 0, over = 0, p_start = 0, p_adv = 0;
    int m_level = 0, m_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            started = 0; pulse = 0; waiting = 0; over = 0; p_start = 0; p_adv = 0;
            m_level = 0; m_count = 0;
        end else begin
            bit se, ae;
            se = start && !p_start;
            ae = adv && !p_adv;
            p_start = start;
            p_adv = adv;
            if (!started) begin
                if (se) begin started = 1; m_level = 1; m_count = 0; end
            end else if (over) begin
                m_count = 0;
            end else if (pulse) begin
                pulse = 0; waiting = 1;
            end else if (waiting) begin
                if (m_level == LEND) over = 1;
                else if (!lf) waiting = 0;
            end else if (lf) begin
                m_level = (m_level < LEND) ? m_level + 1 : m_level;
                m_count = 0;
                pulse = 1;
            end else if (death) begin
                m_count = 0;
            end else if (ae && !sc && m_count < TGT) begin
                m_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (int'(level) != m_level || int'(count) != m_count || lu != pulse) begin
                errors++;
                $display("FAIL model t=%0t level=%0d/%0d count=%0d/%0d levelup=%0b/%0b",
                         $time, level, m_level, count, m_count, lu, pulse);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_adv(input int n);
        for (int i = 0; i < n; i++) begin
            adv = 1; tick();
            adv = 0; tick();
        end
    endtask

    task automatic do_reset();
        rst = 1; tick();
        rst = 0; tick();
    endtask

    task automatic start_game();
        start = 1; tick();
        start = 0; tick();
    endtask

    task automatic next_level();
        lf = 1; tick();
        lf = 0; tick(); tick();
    endtask

    initial begin
        tick(); tick();
        chk("reset_level", int'(level), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_lu", int'(lu), 0);
        rst = 0; tick();
        start = 1; tick();
        chk("start_level", int'(level), 1);
        chk("start_count", int'(count), 0);
        start = 0; tick();
        adv = 1; tick(); tick(); tick();
        adv = 0; tick();
        chk("held_counts_once", int'(count), 1);
        pulse_adv(19);
        chk("count_at_target", int'(count), 20);
        pulse_adv(1);
        chk("count_saturates", int'(count), 20);
        death = 1; tick();
        death = 0; tick();
        pulse_adv(7);
        chk("count_seven", int'(count), 7);
        adv = 1; death = 1; tick();
        chk("death_beats_adv", int'(count), 0);
        adv = 0; death = 0; tick();
        sc = 1; pulse_adv(2); sc = 0;
        chk("startcount_blocks", int'(count), 0);
        pulse_adv(20);
        lf = 1; tick();
        chk("levelup_pulse", int'(lu), 1);
        chk("level_two", int'(level), 2);
        chk("count_cleared", int'(count), 0);
        tick();
        chk("levelup_one_cycle", int'(lu), 0);
        adv = 1; tick(); adv = 0; tick();
        chk("hold_no_count", int'(count), 0);
        chk("hold_level", int'(level), 2);
        lf = 0; tick();
        pulse_adv(1);
        chk("back_to_play", int'(count), 1);
        next_level();
        chk("level_three", int'(level), 3);
        lf = 1; tick();
        chk("level_four", int'(level), 4);
        lf = 0; tick(); tick();
        start_game();
        pulse_adv(3);
        death = 1; tick(); death = 0;
        chk("done_level", int'(level), 4);
        chk("done_count", int'(count), 0);
        lf = 1; tick(); lf = 0; tick();
        chk("done_no_levelup", int'(level), 4);
        rst = 1; tick();
        chk("reset_after_done", int'(level), 0);
        rst = 0; tick();
        start_game();
        next_level();
        pulse_adv(9);
        chk("pre_async_level", int'(level), 2);
        chk("pre_async_count", int'(count), 9);
        @(negedge clk); #1;
        rst = 1; #1;
        chk("async_level", int'(level), 0);
        chk("async_count", int'(count), 0);
        chk("async_lu", int'(lu), 0);
        tick();
        rst = 0; tick();
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            adv   = $urandom_range(0, 1);
            death = ($urandom_range(0, 15) == 0);
            sc    = ($urandom_range(0, 3) == 0);
            lf    = ($urandom_range(0, 24) == 0) ? ~lf : lf;
            fg    = $urandom_range(0, 1);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
